// File: rtl/sid_register_bus_pkg.sv
// Shared types for the SID CPU register interface: register address map, register structs,
// phase encoding and voice address helpers.
package sid;

  typedef enum logic {MOS6581 = 1'b0, MOS8580 = 1'b1} model_e;

  // One-hot SID cycle phase; the localparams are bit positions within phase_t.
  typedef logic [3:0] phase_t;
  localparam int unsigned PHI1      = 0;
  localparam int unsigned PHI1_PHI2 = 1;
  localparam int unsigned PHI2      = 2;
  localparam int unsigned PHI2_PHI1 = 3;

  localparam int unsigned NUM_VOICES = 3;

  typedef enum logic [4:0] {
    FREQ_LO1 = 5'h00, FREQ_HI1 = 5'h01, PW_LO1 = 5'h02, PW_HI1 = 5'h03,
    CR1      = 5'h04, AD1      = 5'h05, SR1    = 5'h06,
    FREQ_LO2 = 5'h07, FREQ_HI2 = 5'h08, PW_LO2 = 5'h09, PW_HI2 = 5'h0a,
    CR2      = 5'h0b, AD2      = 5'h0c, SR2    = 5'h0d,
    FREQ_LO3 = 5'h0e, FREQ_HI3 = 5'h0f, PW_LO3 = 5'h10, PW_HI3 = 5'h11,
    CR3      = 5'h12, AD3      = 5'h13, SR3    = 5'h14,
    FC_LO    = 5'h15, FC_HI    = 5'h16, RES_FILT = 5'h17, MODE_VOL = 5'h18,
    POTX     = 5'h19, POTY     = 5'h1a, OSC3   = 5'h1b, ENV3     = 5'h1c
  } reg_addr_e;

  localparam logic [4:0] READ_ADDR_MIN  = 5'h19;
  localparam logic [4:0] READ_ADDR_MAX  = 5'h1c;
  localparam logic [4:0] WRITE_ADDR_MAX = 5'h18;
  localparam logic [4:0] FILT_ADDR_MIN  = 5'h15;

  typedef struct packed {
    logic [7:0] freq_lo;
    logic [7:0] freq_hi;
    logic [7:0] pw_lo;
    logic [3:0] pw_hi;
    logic       noise;
    logic       pulse;
    logic       sawtooth;
    logic       triangle;
    logic       test;
    logic       ring_mod;
    logic       sync;
    logic       gate;
  } waveform_reg_t;

  // release is a keyword, hence release_val.
  typedef struct packed {
    logic       gate;
    logic [3:0] attack;
    logic [3:0] decay;
    logic [3:0] sustain;
    logic [3:0] release_val;
  } envelope_reg_t;

  typedef struct packed {
    logic [7:0] fc_lo;
    logic [7:0] fc_hi;
    logic [7:0] res_filt;
    logic [7:0] mode_vol;
  } filter_reg_t;

  function automatic logic [1:0] voice_index(logic [4:0] a);
    if (a < 5'd7) return 2'd0;
    else if (a < 5'd14) return 2'd1;
    else return 2'd2;
  endfunction

  function automatic logic [2:0] voice_offset(logic [4:0] a);
    logic [4:0] rel;
    case (voice_index(a))
      2'd0:    rel = a;
      2'd1:    rel = a - 5'd7;
      default: rel = a - 5'd14;
    endcase
    return 3'(rel);
  endfunction

endpackage

// File: rtl/sid_register_bus_if.sv
// 6502-side bus bundle of the SID register interface.
interface sid_register_bus_if;
  import sid::*;

  logic       cs;
  logic       rw;
  logic [4:0] addr;
  logic [7:0] data_i;
  logic [7:0] data_o;
  phase_t     phase;

  modport master (output cs, rw, addr, data_i, phase, input data_o);
  modport slave  (input cs, rw, addr, data_i, phase, output data_o);
endinterface

// File: rtl/sid_register_bus_bus_value.sv
// Floating data bus latch: holds the last driven byte; with SID_BUS_DECAY_EN defined it decays
// to zero after a model-dependent number of millisecond ticks.
module sid_bus_value
  import sid::*;
#(
  parameter logic [9:0] BUS_TTL_6581 = 10'd7,
  parameter logic [9:0] BUS_TTL_8580 = 10'd663
) (
  input  logic       clk,
  input  logic       res,
  input  logic       tick_ms,
  input  model_e     model,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic [7:0] value
);

  logic [7:0] value_d, value_q;

`ifdef SID_BUS_DECAY_EN
  logic [9:0] age_d, age_q;
  logic [9:0] ttl;
  logic       expired;

  assign ttl = (model == MOS8580) ? BUS_TTL_8580 : BUS_TTL_6581;
  // Saturation also expires, covering an age already past a newly selected shorter TTL.
  assign expired = (age_q == ttl) || (age_q == 10'h3ff);

  always_comb begin
    value_d = value_q;
    age_d   = age_q;
    if (load) begin
      value_d = load_data;
      age_d   = '0;
    end else if (expired) begin
      value_d = '0;
    end else if (tick_ms) begin
      age_d = age_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) age_q <= '0;
    else     age_q <= age_d;
  end
`else
  logic unused_decay;
  assign unused_decay = ^{tick_ms, model, BUS_TTL_6581, BUS_TTL_8580};

  always_comb begin
    value_d = value_q;
    if (load) value_d = load_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (res) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/sid_register_bus.sv
// SID register interface: decodes bus writes into voice/envelope/filter registers and serves
// readback; floating-bus decay is enabled by defining SID_BUS_DECAY_EN.
module sid_register_bus
  import sid::*;
#(
  parameter logic [9:0] BUS_TTL_6581 = 10'd7,
  parameter logic [9:0] BUS_TTL_8580 = 10'd663
) (
  input  logic                clk,
  input  logic                res,
  input  logic                tick_ms,
  input  model_e              model,
  sid_register_bus_if.slave   bus,
  input  logic [7:0]          pot_x,
  input  logic [7:0]          pot_y,
  input  logic [7:0]          osc3,
  input  logic [7:0]          env3,
  output waveform_reg_t       voice_o [NUM_VOICES],
  output envelope_reg_t       env_o   [NUM_VOICES],
  output filter_reg_t         filt_o
);

  waveform_reg_t voice_d [NUM_VOICES];
  waveform_reg_t voice_q [NUM_VOICES];
  envelope_reg_t env_d   [NUM_VOICES];
  envelope_reg_t env_q   [NUM_VOICES];
  filter_reg_t   filt_d, filt_q;
  logic [7:0]    data_d, data_q;

  logic       wr_en, rd_en, rd_src, bus_load;
  logic [7:0] rd_byte, load_data, bus_value;
  logic [1:0] v_idx;
  logic [2:0] v_off;

  assign wr_en  = bus.cs & ~bus.rw & bus.phase[PHI2_PHI1];
  assign rd_en  = bus.cs &  bus.rw & bus.phase[PHI2];
  assign rd_src = (bus.addr >= READ_ADDR_MIN) && (bus.addr <= READ_ADDR_MAX);
  assign v_idx  = voice_index(bus.addr);
  assign v_off  = voice_offset(bus.addr);

  always_comb begin
    rd_byte = bus_value;
    case (bus.addr)
      POTX:    rd_byte = pot_x;
      POTY:    rd_byte = pot_y;
      OSC3:    rd_byte = osc3;
      ENV3:    rd_byte = env3;
      default: ;
    endcase
  end

  // Readable addresses also drive the bus, so they refresh the floating value.
  assign bus_load  = wr_en | (rd_en & rd_src);
  assign load_data = wr_en ? bus.data_i : rd_byte;
  assign data_d    = rd_en ? rd_byte : data_q;

  always_comb begin
    voice_d = voice_q;
    env_d   = env_q;
    filt_d  = filt_q;
    if (wr_en && bus.addr < FILT_ADDR_MIN) begin
      case (v_off)
        3'd0: voice_d[v_idx].freq_lo = bus.data_i;
        3'd1: voice_d[v_idx].freq_hi = bus.data_i;
        3'd2: voice_d[v_idx].pw_lo   = bus.data_i;
        3'd3: voice_d[v_idx].pw_hi   = bus.data_i[3:0];
        3'd4: begin
          {voice_d[v_idx].noise, voice_d[v_idx].pulse, voice_d[v_idx].sawtooth,
           voice_d[v_idx].triangle, voice_d[v_idx].test, voice_d[v_idx].ring_mod,
           voice_d[v_idx].sync, voice_d[v_idx].gate} = bus.data_i;
          env_d[v_idx].gate = bus.data_i[0];
        end
        3'd5: {env_d[v_idx].attack, env_d[v_idx].decay} = bus.data_i;
        3'd6: {env_d[v_idx].sustain, env_d[v_idx].release_val} = bus.data_i;
        default: ;
      endcase
    end else if (wr_en && bus.addr <= WRITE_ADDR_MAX) begin
      case (bus.addr)
        FC_LO:    filt_d.fc_lo    = bus.data_i;
        FC_HI:    filt_d.fc_hi    = bus.data_i;
        RES_FILT: filt_d.res_filt = bus.data_i;
        default:  filt_d.mode_vol = bus.data_i;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        voice_q[i] <= '0;
        env_q[i]   <= '0;
      end
      filt_q <= '0;
      data_q <= '0;
    end else begin
      voice_q <= voice_d;
      env_q   <= env_d;
      filt_q  <= filt_d;
      data_q  <= data_d;
    end
  end

  sid_bus_value #(
    .BUS_TTL_6581 (BUS_TTL_6581),
    .BUS_TTL_8580 (BUS_TTL_8580)
  ) u_bus_value (
    .clk       (clk),
    .res       (res),
    .tick_ms   (tick_ms),
    .model     (model),
    .load      (bus_load),
    .load_data (load_data),
    .value     (bus_value)
  );

  assign voice_o    = voice_q;
  assign env_o      = env_q;
  assign filt_o     = filt_q;
  assign bus.data_o = data_q;

endmodule

// File: doc/sid_register_bus.md
# sid_register_bus

CPU-side register interface for the SID core: decodes 6502 bus writes into per-voice waveform and envelope register structs plus raw filter/volume bytes, and serves bus reads of POTX/POTY/OSC3/ENV3. It is the writer for every `sid::waveform_reg_t` consumed by the voice waveform generators. It also models the SID's floating data bus: the last value driven on the bus is returned for write-only addresses and decays to zero after a model-dependent time.

## Interface
Parameters:
- BUS_TTL_6581, 10'd7, bus value lifetime on the 6581, in ms ticks.
- BUS_TTL_8580, 10'd663, bus value lifetime on the 8580, in ms ticks.

Ports:
- clk  in  1  system clock.
- res  in  1  reset; synchronous, active-high (already decided).
- tick_ms  in  1  one-cycle pulse every millisecond.
- model  in  sid::model_e  chip model.
- phase  in  sid::phase_t  SID cycle phase one-hot.
- cs  in  1  chip select, active-high.
- rw  in  1  1 = read, 0 = write.
- addr  in  5  register address, 0x00–0x1f.
- data_i  in  8  write data.
- pot_x, pot_y, osc3, env3  in  8 each  readback sources.
- data_o  out  8  read data.
- voice_o  out  sid::waveform_reg_t[3]  waveform registers for voices 0–2.
- env_o  out  sid::envelope_reg_t[3]  gate/attack/decay/sustain/release for voices 0–2.
- filt_o  out  sid::filter_reg_t  raw bytes at 0x15–0x18.

## Operation
- Voice n base address is 7n. Offsets:
  - +0 freq_lo, +1 freq_hi, +2 pw_lo, +3 pw_hi (bits 3:0 stored, 7:4 dropped).
  - +4 control: b0 gate, b1 sync, b2 ring_mod, b3 test, b4 triangle, b5 sawtooth, b6 pulse, b7 noise.
  - +5 attack/decay, +6 sustain/release.
- Write: `cs & ~rw & phase[sid::PHI2_PHI1]`.
  - Addresses 0x00–0x18: the target field takes data_i.
  - Addresses 0x19–0x1f: no register changes.
  - Every write loads bus_value = data_i.
- Read: `cs & rw & phase[sid::PHI2]`. data_o takes:
  - pot_x for 0x19, pot_y for 0x1a, osc3 for 0x1b, env3 for 0x1c.
  - bus_value for all other addresses.
  - Reads of 0x19–0x1c also load bus_value with the returned byte.
- Decay: bus_age counts tick_ms while no bus load occurs.
  - When bus_age equals the model TTL, bus_value becomes 0 and bus_age holds.
  - Any bus load clears bus_age.
- Simultaneous bus load and TTL expiry: the load wins; bus_value = new data, bus_age = 0.
- Reset: all register fields, data_o, bus_value and bus_age are 0.
  - Reset asserted mid-transaction discards the access.
  - Reset overrides everything else on the same cycle.

## Timing
- Register outputs and bus_value update on the clk edge ending the write-qualifying cycle; they are visible to consumers the following cycle.
- data_o is registered.
  - Valid from the clk after the read-qualifying cycle.
  - Holds until the next read or reset.
- A write followed by a read of a write-only address in the next SID cycle returns the written byte.
- Changing model mid-count compares against the new TTL from the next cycle.
  - If bus_age already exceeds the new TTL, the value is cleared once the counter reaches saturation 10'h3ff, not earlier.

## Configuration
- `SID_BUS_DECAY_EN` defined: decay logic as described.
- Undefined:
  - bus_age is removed.
  - bus_value never decays and holds until the next bus load or reset.
  - BUS_TTL_* are unused.

## Structure
- Package `sid` holds:
  - `reg_addr_e`, the register address enum: FREQ_LO1 … ENV3.
  - `waveform_reg_t`, `envelope_reg_t`, `filter_reg_t`.
  - Readable-address range constants 0x19–0x1c.
- Sub-module `sid_bus_value` holds bus_value, bus_age, TTL selection and the decay macro.
  - Inputs: clk, res, tick_ms, model, load, load_data.
  - Output: value.
- The top level holds only address decode and register storage.

## Test plan
- Reset, then read 0x00 → data_o = 0x00; all voice_o/env_o fields are 0.
- Write 0x24 to 0x07, then write 0xf3 to 0x0a (pw_hi v1) → voice_o[1].freq_lo = 0x24, voice_o[1].pw_hi = 4'h3; voice 0 unchanged.
- Write 0x89 to 0x12 (control v2) → voice_o[2].noise = 1, test = 1, gate = 1, all other bits 0.
- With osc3 = 0x5a, read 0x1b → data_o = 0x5a; a subsequent read of 0x00 → 0x5a.
- 6581 decay, `SID_BUS_DECAY_EN` on: write 0xaa to 0x18, read 0x1d after 6 tick_ms pulses → 0xaa; read after the 7th → 0x00.
  - Repeat with 8580: 662 ticks → 0xaa, 663 → 0x00.
  - Repeat with macro off: 1000 ticks → 0xaa.
- Write 0x55 on the same cycle the TTL expires → subsequent read of 0x1e = 0x55, and a further 6 ticks (6581) still return 0x55.
